// File: rtl/trap_controller.sv
// trap_controller
// Machine-mode trap sequencer for a single-issue pipeline. Samples the decode
// events and level interrupts while running, records mepc/mcause and the
// interrupt-enable stack on entry, and steers the next-PC mux for exactly
// one TRAP or RET cycle (longer while the pipeline is stalled).
module trap_controller #(
   parameter logic [31:0] RESET_MTVEC = 32'h0000_0100
) (
   input  logic        I_clk,
   input  logic        I_rst_n,
   input  logic        I_stall,
   input  logic [31:0] I_pc,
   input  logic        I_illegal,
   input  logic        I_ebreak,
   input  logic        I_ecall,
   input  logic        I_mret,
   input  logic        I_irq_ext,
   input  logic        I_irq_timer,
   input  logic        I_csr_we,
   input  logic [11:0] I_csr_addr,
   input  logic [31:0] I_csr_wdata,
   output logic [31:0] O_csr_rdata,
   output logic        O_exception,
   output logic        O_privsel,
   output logic [31:0] O_mevect,
   output logic [31:0] O_mepc,
   output logic        O_flush
);

   localparam logic [11:0] CSR_MSTATUS = 12'h300;
   localparam logic [11:0] CSR_MIE     = 12'h304;
   localparam logic [11:0] CSR_MTVEC   = 12'h305;
   localparam logic [11:0] CSR_MEPC    = 12'h341;
   localparam logic [11:0] CSR_MCAUSE  = 12'h342;

   localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
   localparam logic [31:0] CAUSE_EBREAK  = 32'd3;
   localparam logic [31:0] CAUSE_ECALL   = 32'd11;
   localparam logic [31:0] CAUSE_IRQ_EXT = 32'h8000_000B;
   localparam logic [31:0] CAUSE_IRQ_TMR = 32'h8000_0007;

   typedef enum logic [1:0] {
      ST_RUN  = 2'd0,
      ST_TRAP = 2'd1,
      ST_RET  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic        mstatus_mie_q, mstatus_mie_d;
   logic        mstatus_mpie_q, mstatus_mpie_d;
   logic        mie_meie_q, mie_meie_d;
   logic        mie_mtie_q, mie_mtie_d;
   logic [31:0] mtvec_q, mtvec_d;
   logic [31:0] mepc_q, mepc_d;
   logic [31:0] mcause_q, mcause_d;
   logic        exception_q, exception_d;
   logic        privsel_q, privsel_d;
   logic        flush_q, flush_d;

   logic        sample_s;
   logic        irq_ext_en_s;
   logic        irq_tmr_en_s;
   logic        trap_take_s;
   logic        mret_take_s;
   logic [31:0] cause_s;
   logic        csr_wr_s;

   // Events only count in RUN on an unstalled cycle; interrupts also need both enables.
   assign sample_s     = (state_q == ST_RUN) && !I_stall;
   assign irq_ext_en_s = I_irq_ext   && mstatus_mie_q && mie_meie_q;
   assign irq_tmr_en_s = I_irq_timer && mstatus_mie_q && mie_mtie_q;

   // Priority resolution of the sampled decode events and interrupts.
   always_comb begin
      trap_take_s = 1'b0;
      mret_take_s = 1'b0;
      cause_s     = 32'd0;
      if (sample_s) begin
         if (I_illegal) begin
            trap_take_s = 1'b1;
            cause_s     = CAUSE_ILLEGAL;
         end else if (I_ebreak) begin
            trap_take_s = 1'b1;
            cause_s     = CAUSE_EBREAK;
         end else if (I_ecall) begin
            trap_take_s = 1'b1;
            cause_s     = CAUSE_ECALL;
         end else if (I_mret) begin
            mret_take_s = 1'b1;
         end else if (irq_ext_en_s) begin
            trap_take_s = 1'b1;
            cause_s     = CAUSE_IRQ_EXT;
         end else if (irq_tmr_en_s) begin
            trap_take_s = 1'b1;
            cause_s     = CAUSE_IRQ_TMR;
         end else begin
            trap_take_s = 1'b0;
         end
      end else begin
         trap_take_s = 1'b0;
      end
   end

   // A software CSR write loses to any trap or mret accepted in the same cycle.
   assign csr_wr_s = sample_s && I_csr_we && !trap_take_s && !mret_take_s;

   // Next-state logic for the sequencer FSM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_RUN: begin
            if (trap_take_s) begin
               state_d = ST_TRAP;
            end else if (mret_take_s) begin
               state_d = ST_RET;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_TRAP: begin
            if (!I_stall) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_TRAP;
            end
         end
         ST_RET: begin
            if (!I_stall) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_RET;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Next-state logic for the CSR file: trap entry, mret unwind, or software write.
   always_comb begin
      mstatus_mie_d  = mstatus_mie_q;
      mstatus_mpie_d = mstatus_mpie_q;
      mie_meie_d     = mie_meie_q;
      mie_mtie_d     = mie_mtie_q;
      mtvec_d        = mtvec_q;
      mepc_d         = mepc_q;
      mcause_d       = mcause_q;
      if (trap_take_s) begin
         mepc_d         = I_pc;
         mcause_d       = cause_s;
         mstatus_mpie_d = mstatus_mie_q;
         mstatus_mie_d  = 1'b0;
      end else if (mret_take_s) begin
         mstatus_mie_d  = mstatus_mpie_q;
         mstatus_mpie_d = 1'b1;
      end else if (csr_wr_s) begin
         case (I_csr_addr)
            CSR_MSTATUS: begin
               mstatus_mie_d  = I_csr_wdata[3];
               mstatus_mpie_d = I_csr_wdata[7];
            end
            CSR_MIE: begin
               mie_mtie_d = I_csr_wdata[7];
               mie_meie_d = I_csr_wdata[11];
            end
            CSR_MTVEC:  mtvec_d  = {I_csr_wdata[31:2], 2'b00};
            CSR_MEPC:   mepc_d   = {I_csr_wdata[31:2], 2'b00};
            CSR_MCAUSE: mcause_d = I_csr_wdata;
            default:    mcause_d = mcause_q;
         endcase
      end else begin
         mcause_d = mcause_q;
      end
   end

   // Mux-select outputs are decoded from the next state so they come straight from flops.
   always_comb begin
      exception_d = (state_d == ST_TRAP);
      privsel_d   = (state_d == ST_RET);
      flush_d     = (state_d != ST_RUN);
   end

   // State, CSR and output registers; reset aborts any TRAP/RET in progress.
   always_ff @(posedge I_clk or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_q        <= ST_RUN;
         mstatus_mie_q  <= 1'b0;
         mstatus_mpie_q <= 1'b0;
         mie_meie_q     <= 1'b0;
         mie_mtie_q     <= 1'b0;
         mtvec_q        <= RESET_MTVEC;
         mepc_q         <= 32'd0;
         mcause_q       <= 32'd0;
         exception_q    <= 1'b0;
         privsel_q      <= 1'b0;
         flush_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         mstatus_mie_q  <= mstatus_mie_d;
         mstatus_mpie_q <= mstatus_mpie_d;
         mie_meie_q     <= mie_meie_d;
         mie_mtie_q     <= mie_mtie_d;
         mtvec_q        <= mtvec_d;
         mepc_q         <= mepc_d;
         mcause_q       <= mcause_d;
         exception_q    <= exception_d;
         privsel_q      <= privsel_d;
         flush_q        <= flush_d;
      end
   end

   // Combinational CSR read port; unmapped addresses read as zero.
   always_comb begin
      O_csr_rdata = 32'd0;
      case (I_csr_addr)
         CSR_MSTATUS: O_csr_rdata = {24'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
         CSR_MIE:     O_csr_rdata = {20'd0, mie_meie_q, 3'd0, mie_mtie_q, 7'd0};
         CSR_MTVEC:   O_csr_rdata = mtvec_q;
         CSR_MEPC:    O_csr_rdata = mepc_q;
         CSR_MCAUSE:  O_csr_rdata = mcause_q;
         default:     O_csr_rdata = 32'd0;
      endcase
   end

   assign O_exception = exception_q;
   assign O_privsel   = privsel_q;
   assign O_flush     = flush_q;
   assign O_mevect    = mtvec_q;
   assign O_mepc      = mepc_q;

endmodule

// File: doc/trap_controller.md
TRAP_CONTROLLER -- requirements
Module: trap_controller

Interface
REQ-001 Parameter: RESET_MTVEC, 32'h0000_0100, trap vector base loaded at reset.
REQ-002 Port: I_clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: I_rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: I_stall  in  1  pipeline stall; events are sampled only when 0.
REQ-005 Port: I_pc  in  32  PC of the instruction currently in decode.
REQ-006 Port: I_illegal / I_ebreak / I_ecall / I_mret  in  1 each  decode events for I_pc.
REQ-007 Port: I_irq_ext / I_irq_timer  in  1 each  level-sensitive interrupt requests.
REQ-008 Port: I_csr_we  in  1; I_csr_addr  in  12; I_csr_wdata  in  32  CSR write port.
REQ-009 Port: O_csr_rdata  out  32  combinational read of CSR at I_csr_addr; 0 for unmapped addresses.
REQ-010 Port: O_exception  out  1  drives the next-PC mux exception select.
REQ-011 Port: O_privsel  out  1  next-PC mux select: 0 = sequential PC, 1 = O_mepc.
REQ-012 Port: O_mevect  out  32  trap target (mtvec); O_mepc  out  32  return address.
REQ-013 Port: O_flush  out  1  kill the instruction in decode.

Function
REQ-014 CSRs: mstatus 0x300 (MIE bit3, MPIE bit7, other bits read 0), mie 0x304 (MTIE bit7, MEIE bit11, other bits read 0), mtvec 0x305, mepc 0x341, mcause 0x342.
REQ-015 mtvec[1:0] and mepc[1:0] SHALL be forced to 0 on every write.
REQ-016 FSM states: RUN, TRAP, RET; reset state RUN.
REQ-017 Event priority in RUN with I_stall=0: illegal (cause 2) > ebreak (3) > ecall (11) > mret > ext irq (32'h8000_000B) > timer irq (32'h8000_0007).
REQ-018 An interrupt is taken only if mstatus.MIE=1 and its mie enable bit is 1.
REQ-019 Trap accepted: mepc <= I_pc, mcause <= cause, MPIE <= MIE, MIE <= 0, next state TRAP.
REQ-020 TRAP: O_exception=1 and O_flush=1; held while I_stall=1; returns to RUN on the first cycle with I_stall=0.
REQ-021 mret accepted: MIE <= MPIE, MPIE <= 1, next state RET.
REQ-022 RET: O_privsel=1 and O_flush=1; held while I_stall=1; returns to RUN on the first cycle with I_stall=0.
REQ-023 O_mevect SHALL always equal mtvec; O_mepc SHALL always equal mepc.
REQ-024 In TRAP and RET, all decode events and interrupts are ignored; pending level interrupts are re-evaluated in RUN.
REQ-025 CSR write takes effect at the clock edge only in RUN with I_stall=0 and no trap/mret accepted that cycle; otherwise it is dropped.
REQ-026 Latency: event sampled at edge N; O_exception/O_privsel high during cycle N+1; earliest next trap accepted at the edge that ends the TRAP/RET cycle.
REQ-027 mret with an enabled pending interrupt and MPIE=1: mret is taken first; the interrupt is taken in the first RUN cycle after RET.
REQ-028 O_exception and O_privsel SHALL never be 1 simultaneously.

Reset
REQ-029 On I_rst_n=0, asynchronously: state=RUN, mstatus=0, mie=0, mtvec=RESET_MTVEC, mepc=0, mcause=0; O_exception, O_privsel, O_flush=0.
REQ-030 Reset asserted in TRAP or RET SHALL abort the state immediately with no CSR side effects after release.

Verification
REQ-031 Reset release, no events -> O_mevect=32'h0000_0100, O_exception=0, O_privsel=0, O_csr_rdata(0x300)=0.
REQ-032 I_pc=32'h0000_0040 with I_ecall=1 -> next cycle O_exception=1, mepc=32'h40, mcause=11, MIE=0.
REQ-033 Same cycle I_illegal=1 and I_ecall=1 -> mcause=2 only; one TRAP cycle.
REQ-034 Write mtvec=32'h0000_0203 -> readback 32'h0000_0200; write mstatus=32'h8 and mie=32'h800, assert I_irq_ext at I_pc=32'h80 -> mcause=32'h8000_000B, mepc=32'h80, MPIE=1.
REQ-035 After REQ-034, I_mret=1 with I_irq_ext still high -> one RET cycle (O_privsel=1, O_mepc=32'h80), MIE=1, then trap re-entered next RUN cycle.
REQ-036 I_stall=1 for 3 cycles while in TRAP -> O_exception stays 1 for 4 cycles; simultaneous CSR write in accept cycle dropped.
